// File: rtl/rr_stream_arb2.sv
// rtl/rr_stream_arb2.sv - two-input round-robin stream arbiter with registered output (optional burst lock: RR_ARB_LOCK_EN)
module rr_stream_arb2 #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i0_valid,
    input  logic [DW-1:0] i0_data,
    output logic          i0_ready,
    input  logic          i1_valid,
    input  logic [DW-1:0] i1_data,
    output logic          i1_ready,
`ifdef RR_ARB_LOCK_EN
    input  logic          i0_last,
    input  logic          i1_last,
    output logic          y_last,
`endif
    output logic          y_valid,
    input  logic          y_ready,
    output logic [DW-1:0] y_data,
    output logic          sel
);

    logic can_load;
    logic last_gnt;
    logic allow0, allow1;
    logic req0, req1;
    logic gnt0, gnt1;
    logic acc0, acc1;

    // The output register may load whenever it is empty or being drained this cycle.
    assign can_load = !y_valid || y_ready;

    assign req0 = i0_valid && allow0;
    assign req1 = i1_valid && allow1;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0 && req1) begin
            gnt0 = last_gnt;
            gnt1 = !last_gnt;
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
    end

    assign i0_ready = can_load && gnt0;
    assign i1_ready = can_load && gnt1;
    assign acc0     = i0_valid && i0_ready;
    assign acc1     = i1_valid && i1_ready;

`ifdef RR_ARB_LOCK_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } lock_t;

    lock_t state, state_nxt;
    logic  acc_last;

    assign acc_last = acc1 ? i1_last : i0_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Any accepted beat decides the next state: a last beat releases, otherwise lock to its channel.
    always_comb begin
        state_nxt = state;
        if (acc0 || acc1) begin
            if (acc_last) begin
                state_nxt = IDLE;
            end else if (acc1) begin
                state_nxt = LOCK1;
            end else begin
                state_nxt = LOCK0;
            end
        end
    end

    always_comb begin
        allow0 = 1'b1;
        allow1 = 1'b1;
        case (state)
            LOCK0:   allow1 = 1'b0;
            LOCK1:   allow0 = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_last <= 1'b0;
        end else if (acc0 || acc1) begin
            y_last <= acc_last;
        end
    end
`else
    assign allow0 = 1'b1;
    assign allow1 = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_valid  <= 1'b0;
            y_data   <= '0;
            sel      <= 1'b0;
            last_gnt <= 1'b1;
        end else if (acc0 || acc1) begin
            y_valid  <= 1'b1;
            y_data   <= acc1 ? i1_data : i0_data;
            sel      <= acc1;
            last_gnt <= acc1;
        end else if (y_ready) begin
            y_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_stream_arb2.sv
// tb/tb_rr_stream_arb2.sv - scoreboard bench for rr_stream_arb2 (lock cases with RR_ARB_LOCK_EN)
module tb_rr_stream_arb2;

    localparam int DW = 8;

    logic          clk;
    logic          rst_n;
    logic          i0_valid, i1_valid;
    logic [DW-1:0] i0_data, i1_data;
    logic          i0_ready, i1_ready;
    logic          i0_last, i1_last;
    logic          y_valid, y_ready, sel;
    logic [DW-1:0] y_data;
`ifdef RR_ARB_LOCK_EN
    logic          y_last;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          ch;
        logic [DW-1:0] data;
        logic          last;
    } sb_item_t;

    sb_item_t sb_q[$];

    logic          m_yv, m_sel, m_ylast, m_last_gnt;
    logic [DW-1:0] m_yd;
    int            m_lock;

    rr_stream_arb2 #(.DW(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i0_valid (i0_valid),
        .i0_data  (i0_data),
        .i0_ready (i0_ready),
        .i1_valid (i1_valid),
        .i1_data  (i1_data),
        .i1_ready (i1_ready),
`ifdef RR_ARB_LOCK_EN
        .i0_last  (i0_last),
        .i1_last  (i1_last),
        .y_last   (y_last),
`endif
        .y_valid  (y_valid),
        .y_ready  (y_ready),
        .y_data   (y_data),
        .sel      (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model evaluated mid-cycle: checks readies/outputs, then scores and predicts the coming edge.
    always @(negedge clk) begin
        logic a0, a1, r0, r1, g0, g1, e0, e1, can, k;
        sb_item_t it;
        if (!rst_n) begin
            m_yv = 1'b0; m_yd = '0; m_sel = 1'b0; m_ylast = 1'b0;
            m_last_gnt = 1'b1; m_lock = 0;
            sb_q.delete();
        end else begin
            can = !m_yv || y_ready;
            a0 = 1'b1;
            a1 = 1'b1;
            if (m_lock == 1) a1 = 1'b0;
            if (m_lock == 2) a0 = 1'b0;
            r0 = i0_valid && a0;
            r1 = i1_valid && a1;
            if (r0 && r1) begin
                g0 = m_last_gnt;
                g1 = !m_last_gnt;
            end else begin
                g0 = r0;
                g1 = r1;
            end
            e0 = can && g0;
            e1 = can && g1;
            check("i0_ready", {31'd0, i0_ready}, {31'd0, e0});
            check("i1_ready", {31'd0, i1_ready}, {31'd0, e1});
            check("y_valid", {31'd0, y_valid}, {31'd0, m_yv});
            check("y_data_hold", {24'd0, y_data}, {24'd0, m_yd});
            check("sel_hold", {31'd0, sel}, {31'd0, m_sel});
`ifdef RR_ARB_LOCK_EN
            check("y_last", {31'd0, y_last}, {31'd0, m_ylast});
`endif
            if (m_yv && y_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    it = sb_q.pop_front();
                    check("sb_data", {24'd0, y_data}, {24'd0, it.data});
                    check("sb_sel", {31'd0, sel}, {31'd0, it.ch});
                end
            end
            if (e0 || e1) begin
                k = e1;
                it.ch   = k;
                it.data = k ? i1_data : i0_data;
                it.last = k ? i1_last : i0_last;
                sb_q.push_back(it);
                m_yv = 1'b1;
                m_yd = it.data;
                m_sel = k;
                m_ylast = it.last;
                m_last_gnt = k;
`ifdef RR_ARB_LOCK_EN
                m_lock = it.last ? 0 : (k ? 2 : 1);
`endif
            end else if (y_ready) begin
                m_yv = 1'b0;
            end
        end
    end

    task automatic drive(input logic v0, input logic [DW-1:0] d0, input logic v1,
                         input logic [DW-1:0] d1, input logic yr, input logic l0, input logic l1);
        i0_valid = v0; i0_data = d0; i0_last = l0;
        i1_valid = v1; i1_data = d1; i1_last = l1;
        y_ready  = yr;
        @(posedge clk);
        #1;
    endtask

    logic          exp_sel [4];
    logic [DW-1:0] exp_dat [4];

    initial begin
        exp_sel[0] = 1'b0; exp_sel[1] = 1'b1; exp_sel[2] = 1'b0; exp_sel[3] = 1'b1;
        exp_dat[0] = 8'h11; exp_dat[1] = 8'h22; exp_dat[2] = 8'h11; exp_dat[3] = 8'h22;

        rst_n = 1'b0;
        i0_valid = 1'b0; i0_data = '0; i0_last = 1'b0;
        i1_valid = 1'b0; i1_data = '0; i1_last = 1'b0;
        y_ready = 1'b0;
        #12;
        check("rst_y_valid", {31'd0, y_valid}, 32'd0);
        check("rst_y_data", {24'd0, y_data}, 32'd0);
        check("rst_sel", {31'd0, sel}, 32'd0);
`ifdef RR_ARB_LOCK_EN
        check("rst_y_last", {31'd0, y_last}, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // single channel
        drive(1'b1, 8'h5A, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        check("single_valid", {31'd0, y_valid}, 32'd1);
        check("single_data", {24'd0, y_data}, 32'h5A);
        check("single_sel", {31'd0, sel}, 32'd0);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);

        // channel 1 alone moves the pointer, so channel 0 wins the contention that follows
        drive(1'b0, 8'h00, 1'b1, 8'h44, 1'b1, 1'b1, 1'b1);
        check("ptr_sel", {31'd0, sel}, 32'd1);
        check("ptr_data", {24'd0, y_data}, 32'h44);

        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1);
            check($sformatf("cont_sel%0d", i), {31'd0, sel}, {31'd0, exp_sel[i]});
            check($sformatf("cont_data%0d", i), {24'd0, y_data}, {24'd0, exp_dat[i]});
        end

        // backpressure
        drive(1'b1, 8'h33, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1);
            check($sformatf("bp_data%0d", i), {24'd0, y_data}, 32'h33);
            check($sformatf("bp_sel%0d", i), {31'd0, sel}, 32'd0);
        end
        drive(1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1);
        check("bp_release_valid", {31'd0, y_valid}, 32'd1);
        check("bp_release_data", {24'd0, y_data}, 32'h22);
        check("bp_release_sel", {31'd0, sel}, 32'd1);

        // asynchronous reset with a word in flight
        i0_valid = 1'b0; i1_valid = 1'b0; y_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_y_valid", {31'd0, y_valid}, 32'd0);
        check("async_y_data", {24'd0, y_data}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1);
        check("post_rst_sel", {31'd0, sel}, 32'd0);
        check("post_rst_data", {24'd0, y_data}, 32'h11);

`ifdef RR_ARB_LOCK_EN
        // channel 1 burst of three beats while channel 0 stays valid
        drive(1'b1, 8'h55, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 8'h11, 1'b1, 8'hB1, 1'b1, 1'b1, 1'b0);
        check("lock_sel0", {31'd0, sel}, 32'd1);
        drive(1'b1, 8'h11, 1'b1, 8'hB2, 1'b1, 1'b1, 1'b0);
        check("lock_sel1", {31'd0, sel}, 32'd1);
        check("lock_data1", {24'd0, y_data}, 32'hB2);
        drive(1'b1, 8'h11, 1'b1, 8'hB3, 1'b1, 1'b1, 1'b1);
        check("lock_sel2", {31'd0, sel}, 32'd1);
        check("lock_last2", {31'd0, y_last}, 32'd1);
        drive(1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1);
        check("unlock_sel", {31'd0, sel}, 32'd0);
        check("unlock_data", {24'd0, y_data}, 32'h11);
`endif

        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        check("sb_left", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
